// File: rtl/reg_bank_8x16.sv
// reg_bank_8x16: eight 16-bit general-purpose registers, each exposed in
// parallel as a flop output. There are two write sources: a single-cycle
// write-back port, and a byte-serial loader that assembles 16-bit words.
module reg_bank_8x16 (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CLR,
  input  logic        WE,
  input  logic [2:0]  WA,
  input  logic [15:0] WD,
  input  logic        BL_V,
  input  logic [2:0]  BL_A,
  input  logic [7:0]  BL_D,
  output logic        BL_RDY,
  output logic        BL_DONE,
  output logic [15:0] R0,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] R3,
  output logic [15:0] R4,
  output logic [15:0] R5,
  output logic [15:0] R6,
  output logic [15:0] R7
);

  typedef enum logic [1:0] {
    LO     = 2'd0,
    HI     = 2'd1,
    COMMIT = 2'd2
  } ld_state_t;

  ld_state_t   state;
  ld_state_t   state_nxt;
  logic [2:0]  addr;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic        bl_done;
  logic [15:0] regs [8];

  logic accept;
  logic commit_go;

  // A byte is taken only when the loader is ready. BL_RDY decodes the state
  // register alone, so it never depends on BL_V.
  assign BL_RDY    = (state != COMMIT);
  assign accept    = BL_V && BL_RDY;
  // Write-back to the same address always wins, so the commit stalls.
  assign commit_go = (state == COMMIT) && !(WE && (WA == addr));

  assign BL_DONE = bl_done;
  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];
  assign R4 = regs[4];
  assign R5 = regs[5];
  assign R6 = regs[6];
  assign R7 = regs[7];

  // Loader next-state logic; CLR returns the loader to LO.
  always_comb begin
    state_nxt = state;
    case (state)
      LO:      if (accept) state_nxt = HI;
      HI:      if (accept) state_nxt = COMMIT;
      COMMIT:  if (commit_go) state_nxt = LO;
      default: state_nxt = LO;
    endcase
    if (CLR) state_nxt = LO;
  end

  // Loader state register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= LO;
    else        state <= state_nxt;
  end

  // Latch the target address and low byte in LO, and the high byte in HI.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      addr <= '0;
      lo   <= '0;
      hi   <= '0;
    end else if (CLR) begin
      addr <= '0;
      lo   <= '0;
      hi   <= '0;
    end else if (accept && (state == LO)) begin
      addr <= BL_A;
      lo   <= BL_D;
    end else if (accept && (state == HI)) begin
      hi <= BL_D;
    end
  end

  // Completion pulse, one cycle after the commit edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) bl_done <= 1'b0;
    else        bl_done <= commit_go && !CLR;
  end

  // Register array. Write-back and commit may hit different registers on the
  // same edge. A commit to WA cannot occur, because commit_go excludes it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else if (CLR) begin
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (WE)        regs[WA]   <= WD;
      if (commit_go) regs[addr] <= {hi, lo};
    end
  end

endmodule
